// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake,
// and holds one instruction for decode. Define IFETCH_PERF_EN to add fetch/stall counters.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        valid,
  output logic [31:0] pco,
  output logic [31:0] inst
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SKID, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] pco_d, inst_d;
  logic        valid_d;
  logic        slot_free;

  assign slot_free = !valid || !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    pco_d       = pco;
    inst_d      = inst;
    // an unstalled valid instruction is consumed this cycle
    valid_d     = valid && stall;
    imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
    // S_DROP keeps the abandoned address on the bus until its ack retires it
    imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;

    if (br_taken) begin
      pc_d        = br_target;
      valid_d     = 1'b0;
      skid_pc_d   = 32'h0;
      skid_inst_d = 32'h0;
      case (state_q)
        S_REQ: begin
          if (!imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end
        S_IDLE, S_SKID: state_d = S_REQ;
        default: ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + PC_INC;
            if (slot_free) begin
              valid_d = 1'b1;
              pco_d   = pc_q;
              inst_d  = imem_rdata;
            end else begin
              skid_pc_d   = pc_q;
              skid_inst_d = imem_rdata;
              state_d     = S_SKID;
            end
          end
        end
        S_SKID: begin
          if (slot_free) begin
            valid_d = 1'b1;
            pco_d   = skid_pc_q;
            inst_d  = skid_inst_q;
            state_d = S_REQ;
          end
        end
        S_DROP: if (imem_ack) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      valid       <= 1'b0;
      pco         <= 32'h0;
      inst        <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      valid       <= valid_d;
      pco         <= pco_d;
      inst        <= inst_d;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (state_q == S_REQ && imem_ack && !br_taken) fetch_cnt <= fetch_cnt + 32'd1;
      if (valid && stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential fetch, slow memory, stall/skid, redirects, PC wrap
// and, with IFETCH_PERF_EN, the performance counters.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        valid;
  logic [31:0] pco;
  logic [31:0] inst;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // memory model: accepts one request, acks it lat cycles after it is first seen
  logic        pend = 1'b0;
  int          wait_left = 0;
  int          lat = 1;
  logic [31:0] paddr = 32'h0;
  logic        mem_on = 1'b1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  int          caps = 0;
  int          nval = 0;

  ifetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .valid(valid), .pco(pco), .inst(inst)
`ifdef IFETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend = 1'b0;
      imem_ack = 1'b0;
    end else if (imem_ack) begin
      imem_ack = 1'b0;
      pend = 1'b0;
    end else if (pend) begin
      if (wait_left == 0) begin
        imem_ack = 1'b1;
        imem_rdata = ovr_en ? ovr_data : paddr + 32'h1000_0000;
      end else begin
        wait_left--;
      end
    end
    if (rst_n && !pend && !imem_ack && imem_req && mem_on) begin
      pend = 1'b1;
      paddr = imem_addr;
      wait_left = lat - 1;
      caps++;
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pco", pco, 0);
    chk("rst_inst", inst, 0);
    rst_n = 1'b1;

    // sequential fetch 0,1,2 with one-cycle memory
    tick();
    chk("seq_req", imem_req, 1);
    chk("seq_addr0", imem_addr, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_gap_valid", valid, 0);
      tick();
      chk("seq_valid", valid, 1);
      chk("seq_pco", pco, k);
      chk("seq_inst", inst, 32'h1000_0000 + k);
      chk("seq_next_addr", imem_addr, k + 1);
    end

    // pco=3 presented, then stall for 4 cycles while pc=4 lands in the skid
    tick(); tick();
    chk("pco3", pco, 3);
    stall = 1'b1;
    tick();
    chk("stall_pco_c1", pco, 3);
    chk("stall_valid_c1", valid, 1);
    tick();
    chk("stall_pco_c2", pco, 3);
    chk("skid_req_low", imem_req, 0);
    tick();
    chk("stall_pco_c3", pco, 3);
    tick();
    chk("stall_pco_c4", pco, 3);
    chk("stall_inst_c4", inst, 32'h1000_0003);
    stall = 1'b0;
    lat = 3;
    ovr_en = 1'b1;
    ovr_data = 32'hA5A5_0001;
    tick();
    chk("skid_out_valid", valid, 1);
    chk("skid_out_pco", pco, 4);
    chk("skid_out_inst", inst, 32'h1000_0004);
    chk("after_skid_addr", imem_addr, 5);

    // slow memory: request for pc=5 held for 4 cycles
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("slow_req", imem_req, 1);
      chk("slow_addr", imem_addr, 5);
      chk("slow_valid", valid, 0);
    end
    lat = 1;
    ovr_en = 1'b0;
    tick();
    chk("slow_valid_out", valid, 1);
    chk("slow_pco", pco, 5);
    chk("slow_inst", inst, 32'hA5A5_0001);

    // redirect while pc=7 is outstanding
    tick();
    lat = 3;
    tick();
    chk("pre_br_pco", pco, 6);
    chk("pre_br_addr", imem_addr, 7);
    br_taken = 1'b1;
    br_target = 32'h40;
    tick();
    br_taken = 1'b0;
    chk("drop_valid", valid, 0);
    chk("drop_req", imem_req, 1);
    chk("drop_addr", imem_addr, 7);
    tick();
    chk("drop_addr_hold", imem_addr, 7);
    tick();
    lat = 1;
    tick();
    chk("post_drop_valid", valid, 0);
    chk("post_drop_inst", inst, 32'h1000_0006);
    chk("post_drop_addr", imem_addr, 32'h40);
    tick(); tick();
    chk("br_out_valid", valid, 1);
    chk("br_out_pco", pco, 32'h40);
    chk("br_out_inst", inst, 32'h1000_0040);

    // redirect in the ack cycle while stalled
    stall = 1'b1;
    tick();
    chk("stall_hold_pco", pco, 32'h40);
    br_taken = 1'b1;
    br_target = 32'h80;
    tick();
    br_taken = 1'b0;
    stall = 1'b0;
    chk("flush_valid", valid, 0);
    chk("flush_inst", inst, 32'h1000_0040);
    chk("flush_addr", imem_addr, 32'h80);
    tick(); tick();
    chk("flush_out_pco", pco, 32'h80);
    chk("flush_out_inst", inst, 32'h1000_0080);

    // PC wrap
    tick();
    br_taken = 1'b1;
    br_target = 32'hFFFF_FFFF;
    tick();
    br_taken = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFF);
    tick(); tick();
    chk("wrap_pco", pco, 32'hFFFF_FFFF);
    chk("wrap_inst", inst, 32'h0FFF_FFFF);
    chk("wrap_next_addr", imem_addr, 0);

    // fresh reset, exactly 10 fetches then 3 stall cycles
    rst_n = 1'b0;
    tick(); tick();
    chk("rst2_valid", valid, 0);
    chk("rst2_req", imem_req, 0);
    chk("rst2_pco", pco, 0);
`ifdef IFETCH_PERF_EN
    chk("rst2_fetch_cnt", fetch_cnt, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
`endif
    caps = 0;
    mem_on = 1'b1;
    rst_n = 1'b1;
    for (int t = 0; t < 200 && nval < 10; t++) begin
      tick();
      if (caps >= 10) mem_on = 1'b0;
      if (valid) nval++;
    end
    chk("perf_nval", nval, 10);
    chk("perf_last_pco", pco, 9);
    stall = 1'b1;
    repeat (3) tick();
    chk("perf_stall_pco", pco, 9);
    chk("perf_stall_valid", valid, 1);
    stall = 1'b0;
    tick();
    chk("perf_end_valid", valid, 0);
`ifdef IFETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, 10);
    chk("stall_cnt", stall_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
